// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage core. It produces the en/clear pair for the
// D, E, M and W pipeline registers and the PC enable. It also owns the
// multi-cycle mul/div sequencer and the fetch-discard flag used after a redirect.
//
// Handshake: there is no valid/ready pair here. Every output is a level for the
// current cycle, and a pipeline register obeys clear before en. Inputs are levels,
// except redirect, which is a single-cycle pulse.
module pipeline_hazard_ctrl #(
    parameter int MULDIV_LAT = 32,
    parameter int REG_W      = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] d_rs,
    input  logic [REG_W-1:0] d_rt,
    input  logic             d_uses_rs,
    input  logic             d_uses_rt,
    input  logic [REG_W-1:0] e_rd,
    input  logic             e_is_load,
    input  logic             e_muldiv,
    input  logic             i_wait,
    input  logic             m_wait,
    input  logic             redirect,
    output logic             pc_en,
    output logic             d_en,
    output logic             d_clear,
    output logic             e_en,
    output logic             e_clear,
    output logic             m_en,
    output logic             m_clear,
    output logic             w_en,
    output logic             w_clear,
    output logic             muldiv_busy,
    output logic             muldiv_done,
    output logic             f_discard,
    output logic [1:0]       muldiv_state
);

    localparam int CNT_W = $clog2(MULDIV_LAT) + 1;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    md_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             done_q;
    logic             md_stall;
    logic             load_use;
    logic             e_en_int;

    // Hazard detection from the instructions currently in D and E.
    always_comb begin
        md_stall = e_muldiv && (state != MD_DONE);
        load_use = e_is_load && (e_rd != '0) &&
                   ((d_uses_rs && (d_rs == e_rd)) || (d_uses_rt && (d_rt == e_rd)));
    end

    // Pipeline register controls. The highest-priority stall wins, and redirect
    // flushes on top of it. A pending discard keeps the stale fetch out of D.
    always_comb begin
        pc_en   = 1'b1;
        d_en    = 1'b1;
        d_clear = 1'b0;
        e_en_int = 1'b1;
        e_clear = 1'b0;
        m_en    = 1'b1;
        m_clear = 1'b0;
        w_en    = 1'b1;
        w_clear = 1'b0;
        if (m_wait) begin
            pc_en    = 1'b0;
            d_en     = 1'b0;
            e_en_int = 1'b0;
            m_en     = 1'b0;
            w_clear  = 1'b1;
        end else begin
            if (md_stall) begin
                pc_en    = 1'b0;
                d_en     = 1'b0;
                e_en_int = 1'b0;
                m_clear  = 1'b1;
            end else if (load_use) begin
                pc_en   = 1'b0;
                d_en    = 1'b0;
                e_clear = 1'b1;
            end else if (i_wait) begin
                pc_en   = 1'b0;
                d_clear = 1'b1;
            end
            if (redirect) begin
                pc_en   = 1'b1;
                d_clear = 1'b1;
                e_clear = 1'b1;
                m_clear = 1'b1;
            end
            if (f_discard) begin
                d_clear = 1'b1;
            end
        end
        e_en = e_en_int;
        if (reset) begin
            pc_en   = 1'b0;
            d_en    = 1'b0;
            d_clear = 1'b1;
            e_en    = 1'b0;
            e_clear = 1'b1;
            m_en    = 1'b0;
            m_clear = 1'b1;
            w_en    = 1'b0;
            w_clear = 1'b1;
        end
    end

    // Mul/div sequencer next state. The IDLE cycle plus the BUSY cycles hold E
    // for MULDIV_LAT-1 cycles. DONE releases E on the first cycle E may advance.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            MD_IDLE: begin
                if (e_muldiv && !redirect) begin
                    if (MULDIV_LAT <= 2) begin
                        state_n = MD_DONE;
                    end else begin
                        state_n = MD_BUSY;
                        cnt_n   = CNT_W'(MULDIV_LAT - 2);
                    end
                end
            end
            MD_BUSY: begin
                if (redirect) begin
                    state_n = MD_IDLE;
                    cnt_n   = '0;
                end else if (cnt <= CNT_W'(1)) begin
                    state_n = MD_DONE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            MD_DONE: begin
                if (redirect || e_en_int) begin
                    state_n = MD_IDLE;
                end
            end
            default: begin
                state_n = MD_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Sequencer state, the one-shot done pulse and the fetch-discard flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= MD_IDLE;
            cnt       <= '0;
            done_q    <= 1'b0;
            f_discard <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            done_q <= (state_n == MD_DONE) && (state != MD_DONE);
            if (redirect && i_wait) begin
                f_discard <= 1'b1;
            end else if (!i_wait) begin
                f_discard <= 1'b0;
            end
        end
    end

    // Status and debug views of the sequencer.
    always_comb begin
        muldiv_busy  = (state == MD_BUSY);
        muldiv_done  = done_q;
        muldiv_state = state;
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. A reference model tracks each
// mul/div as "cycles spent in E" and the discard flag as a plain bit. Every
// cycle it checks all twelve control/status outputs, and then it runs directed
// scenarios and a randomized phase.
module tb_pipeline_hazard_ctrl;

    localparam int LAT   = 32;
    localparam int REG_W = 5;
    localparam logic [11:0] RST_VEC = 12'h2A8;

    logic             clk = 1'b0;
    logic             reset;
    logic [REG_W-1:0] d_rs, d_rt, e_rd;
    logic             d_uses_rs, d_uses_rt, e_is_load, e_muldiv;
    logic             i_wait, m_wait, redirect;
    logic             pc_en, d_en, d_clear, e_en, e_clear, m_en, m_clear, w_en, w_clear;
    logic             muldiv_busy, muldiv_done, f_discard;
    logic [1:0]       muldiv_state;

    pipeline_hazard_ctrl #(.MULDIV_LAT(LAT), .REG_W(REG_W)) dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt),
        .e_rd(e_rd), .e_is_load(e_is_load), .e_muldiv(e_muldiv),
        .i_wait(i_wait), .m_wait(m_wait), .redirect(redirect),
        .pc_en(pc_en), .d_en(d_en), .d_clear(d_clear), .e_en(e_en), .e_clear(e_clear),
        .m_en(m_en), .m_clear(m_clear), .w_en(w_en), .w_clear(w_clear),
        .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done), .f_discard(f_discard),
        .muldiv_state(muldiv_state)
    );

    // Clock.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    int          md_age  = 0;     // cycles the current mul/div has spent in E
    bit          md_just = 1'b0;  // it reached completion on the last edge
    bit          fd_mdl  = 1'b0;
    logic [11:0] last_obs;

    // Bit order: pc_en d_en d_clear e_en e_clear m_en m_clear w_en w_clear busy done discard
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [11:0] model_out();
        logic pc, den, dcl, een, ecl, men, mcl, wen, wcl, stall_md, lu;
        logic [2:0] st;
        st = {(md_age >= 1 && md_age <= LAT - 2), md_just, fd_mdl};
        if (reset) return {9'b001010101, st};
        pc = 1; den = 1; dcl = 0; een = 1; ecl = 0; men = 1; mcl = 0; wen = 1; wcl = 0;
        stall_md = e_muldiv && (md_age != LAT - 1);
        lu = e_is_load && (e_rd != 0) &&
             ((d_uses_rs && d_rs == e_rd) || (d_uses_rt && d_rt == e_rd));
        if (m_wait) begin
            pc = 0; den = 0; een = 0; men = 0; wcl = 1;
        end else begin
            if (stall_md) begin pc = 0; den = 0; een = 0; mcl = 1; end
            else if (lu) begin pc = 0; den = 0; ecl = 1; end
            else if (i_wait) begin pc = 0; dcl = 1; end
            if (redirect) begin pc = 1; dcl = 1; ecl = 1; mcl = 1; end
            if (fd_mdl) dcl = 1;
        end
        return {pc, den, dcl, een, ecl, men, mcl, wen, wcl, st};
    endfunction

    task automatic model_clock();
        bit just_n;
        just_n = 0;
        if (reset) begin
            md_age = 0; fd_mdl = 0;
        end else begin
            if (redirect) md_age = 0;
            else if (md_age == LAT - 1) begin
                if (!m_wait) md_age = 0;
            end else if (md_age > 0 || e_muldiv) begin
                md_age++;
                if (md_age == LAT - 1) just_n = 1;
            end
            if (redirect && i_wait) fd_mdl = 1;
            else if (!i_wait) fd_mdl = 0;
        end
        md_just = just_n;
    endtask

    // One cycle: check every output mid-cycle, then clock the model and the DUT.
    task automatic step();
        @(negedge clk);
        last_obs = {pc_en, d_en, d_clear, e_en, e_clear, m_en, m_clear, w_en, w_clear,
                    muldiv_busy, muldiv_done, f_discard};
        chk("ctrl", 32'(last_obs), 32'(model_out()));
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; d_rs = 0; d_rt = 0; e_rd = 0; d_uses_rs = 0; d_uses_rt = 0;
        e_is_load = 0; e_muldiv = 0; i_wait = 0; m_wait = 0; redirect = 0;
    endtask

    initial begin
        int cnt_a, cnt_b, adv;
        bit found;
        idle_inputs();
        reset = 1;
        @(posedge clk);
        #1;
        step();
        chk("rst_vec", 32'(last_obs), 32'(RST_VEC));
        reset = 0;
        step();

        // Load-use on rs, then the same with the zero register.
        e_is_load = 1; e_rd = 3; d_rs = 3; d_uses_rs = 1;
        step();
        chk("lu_pc_en", 32'(last_obs[11]), 0);
        chk("lu_e_clear", 32'(last_obs[7]), 1);
        e_rd = 0; d_rs = 0;
        step();
        chk("lu_zero_pc_en", 32'(last_obs[11]), 1);
        idle_inputs();
        step();

        // Plain divide: stall length, busy length, single done pulse.
        e_muldiv = 1; adv = -1; cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            cnt_a += int'(last_obs[2]);
            cnt_b += int'(last_obs[1]);
            if (last_obs[8]) begin adv = i; break; end
        end
        e_muldiv = 0;
        chk("div_adv_cycle", 32'(adv), 31);
        chk("div_busy_cycles", 32'(cnt_a), 30);
        chk("div_done_pulses", 32'(cnt_b), 1);
        step();

        // Divide completing under m_wait held for 3 cycles.
        e_muldiv = 1; found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            found = (md_age == LAT - 1);
        end
        chk("mw_reach_done", 32'(found), 1);
        m_wait = 1; cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            cnt_a += int'(last_obs[8]);
            cnt_b += int'(last_obs[1]);
        end
        m_wait = 0;
        step();
        cnt_b += int'(last_obs[1]);
        chk("mw_e_en_held", 32'(cnt_a), 0);
        chk("mw_done_pulses", 32'(cnt_b), 1);
        chk("mw_e_en_release", 32'(last_obs[8]), 1);
        e_muldiv = 0;
        step();

        // Redirect while BUSY with counter at 10.
        e_muldiv = 1; found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            found = (md_age == 21);
        end
        chk("rd_reach_cnt10", 32'(found), 1);
        redirect = 1;
        step();
        chk("rd_clears", 32'({last_obs[11], last_obs[9], last_obs[7], last_obs[5]}), 32'hF);
        redirect = 0; e_muldiv = 0; cnt_b = 0;
        step();
        chk("rd_busy_after", 32'(last_obs[2]), 0);
        for (int i = 0; i < 35; i++) begin
            step();
            cnt_b += int'(last_obs[1]);
        end
        chk("rd_no_done", 32'(cnt_b), 0);

        // Redirect with a fetch outstanding for 4 cycles.
        i_wait = 1; redirect = 1; cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) redirect = 0;
            if (i == 4) i_wait = 0;
            step();
            cnt_a += int'(last_obs[0]);
            if (i < 5) cnt_b += int'(last_obs[9]);
        end
        chk("fd_high_cycles", 32'(cnt_a), 4);
        chk("fd_d_clear_cycles", 32'(cnt_b), 5);

        // m_wait together with load-use, then reset in the middle of a divide.
        m_wait = 1; e_is_load = 1; e_rd = 3; d_rs = 3; d_uses_rs = 1;
        step();
        chk("mw_lu_w_clear", 32'(last_obs[3]), 1);
        chk("mw_lu_e_clear", 32'(last_obs[7]), 0);
        idle_inputs();
        e_muldiv = 1;
        for (int i = 0; i < 5; i++) step();
        reset = 1;
        step();
        step();
        chk("rst_mid_div", 32'(last_obs), 32'(RST_VEC));
        idle_inputs();
        step();

        // Randomized phase.
        for (int c = 0; c < 2500; c++) begin
            reset     = ($urandom_range(0, 399) == 0);
            m_wait    = ($urandom_range(0, 5) == 0);
            i_wait    = ($urandom_range(0, 3) == 0);
            redirect  = ($urandom_range(0, 29) == 0);
            e_is_load = ($urandom_range(0, 2) == 0);
            e_rd      = REG_W'($urandom_range(0, 3));
            d_rs      = REG_W'($urandom_range(0, 3));
            d_rt      = REG_W'($urandom_range(0, 3));
            d_uses_rs = 1'($urandom_range(0, 1));
            d_uses_rt = 1'($urandom_range(0, 1));
            if (md_age > 0) e_muldiv = 1;
            else e_muldiv = ($urandom_range(0, 11) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
